// File: rtl/demux4_stream.sv
// Four-way stream demultiplexer: routes each accepted word to one of four
// single-entry output holding registers, each with a wrapping drain counter.
module demux4_stream #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [7:0]       out1_count,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [7:0]       out2_count,
  output logic [WIDTH-1:0] out3_data,
  output logic             out3_valid,
  input  logic             out3_ready,
  output logic [7:0]       out3_count,
  output logic [WIDTH-1:0] out4_data,
  output logic             out4_valid,
  input  logic             out4_ready,
  output logic [7:0]       out4_count
);

  localparam int unsigned NPORTS = 4;
  localparam int unsigned CNT_W  = 8;

  logic [WIDTH-1:0] data_q  [NPORTS];
  logic             valid_q [NPORTS];
  logic [CNT_W-1:0] count_q [NPORTS];
  logic [NPORTS-1:0] ready_vec;
  logic [NPORTS-1:0] drain;
  logic [NPORTS-1:0] load;

  assign ready_vec = {out4_ready, out3_ready, out2_ready, out1_ready};

  // Selected slot can accept if empty or being drained this cycle.
  always_comb begin
    in_ready = !valid_q[in_sel] || ready_vec[in_sel];
  end

  always_comb begin
    load  = '0;
    drain = '0;
    for (int k = 0; k < NPORTS; k++) begin
      drain[k] = valid_q[k] && ready_vec[k];
    end
    if (in_valid && in_ready) begin
      load[in_sel] = 1'b1;
    end
  end

  // A load wins over a drain on the same slot, giving one word per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NPORTS; k++) begin
        data_q[k]  <= '0;
        valid_q[k] <= 1'b0;
        count_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NPORTS; k++) begin
        if (load[k]) begin
          data_q[k]  <= in_data;
          valid_q[k] <= 1'b1;
        end else if (drain[k]) begin
          valid_q[k] <= 1'b0;
        end
        if (drain[k]) begin
          count_q[k] <= count_q[k] + CNT_W'(1);
        end
      end
    end
  end

  assign out1_data  = data_q[0];
  assign out2_data  = data_q[1];
  assign out3_data  = data_q[2];
  assign out4_data  = data_q[3];
  assign out1_valid = valid_q[0];
  assign out2_valid = valid_q[1];
  assign out3_valid = valid_q[2];
  assign out4_valid = valid_q[3];
  assign out1_count = count_q[0];
  assign out2_count = count_q[1];
  assign out3_count = count_q[2];
  assign out4_count = count_q[3];

endmodule
